// File: rtl/divider_sequencer.sv
// divider_sequencer: control FSM for the 8-bit restoring bitslice divider.
// Define DIVSEQ_DIV0_CHECK_EN to abort on a zero divisor through the ERR state.
module divider_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic nBorrow,
    input  logic nZ,
    output logic Load,
    output logic DivShift,
    output logic LoadAcc,
    output logic LoadResult,
    output logic QuotientBit,
    output logic Test,
    output logic Busy,
    output logic Done,
    output logic DivByZero
);
`ifdef DIVSEQ_DIV0_CHECK_EN
    typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ITER, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ITER, DONE} state_t;
`endif
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ok;
    assign Test = 1'b0;
    // A quotient bit is set only when the shifted divisor fits entirely in ACC.
    assign ok = nBorrow & ~nZ;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        Load        = 1'b0;
        DivShift    = 1'b0;
        LoadAcc     = 1'b0;
        LoadResult  = 1'b0;
        QuotientBit = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        DivByZero   = 1'b0;
        case (state_q)
            IDLE: state_d = Start ? LOAD : IDLE;
            LOAD: begin
                Load       = 1'b1;
                LoadAcc    = 1'b1;
                LoadResult = 1'b1;
                Busy       = 1'b1;
                state_d    = ALIGN;
            end
            ALIGN: begin
                DivShift = 1'b1;
                Busy     = 1'b1;
                cnt_d    = '0;
`ifdef DIVSEQ_DIV0_CHECK_EN
                state_d  = nZ ? ITER : ERR;
`else
                state_d  = ITER;
`endif
            end
            ITER: begin
                Busy        = 1'b1;
                DivShift    = 1'b1;
                LoadResult  = 1'b1;
                LoadAcc     = ok;
                QuotientBit = ok;
                cnt_d       = cnt_q + 1'b1;
                state_d     = (cnt_q == CNT_W'(N - 1)) ? DONE : ITER;
            end
            DONE: begin
                Done    = 1'b1;
                Busy    = 1'b1;
                state_d = IDLE;
            end
`ifdef DIVSEQ_DIV0_CHECK_EN
            ERR: begin
                Done      = 1'b1;
                DivByZero = 1'b1;
                Busy      = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: directed checks of the divider sequencer driving a behavioural bitslice datapath.
module tb_divider_sequencer;
    logic Clock = 1'b0;
    logic Reset, Start;
    logic nBorrow, nZ;
    logic Load, DivShift, LoadAcc, LoadResult, QuotientBit, Test, Busy, Done, DivByZero;
    logic [7:0] acc = '0, dh = '0, dl = '0, res = '0, op_a = '0, op_b = '0;
    int asserts = 0, fails = 0, test_bad = 0;

    divider_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .nBorrow(nBorrow), .nZ(nZ),
        .Load(Load), .DivShift(DivShift), .LoadAcc(LoadAcc), .LoadResult(LoadResult),
        .QuotientBit(QuotientBit), .Test(Test), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 Clock = ~Clock;

    assign nBorrow = (acc >= dl);
    assign nZ      = |dh;
    always @(posedge Clock) begin
        if (Load) begin
            dh <= op_b;
            dl <= '0;
        end else if (DivShift) {dh, dl} <= {dh, dl} >> 1;
        if (LoadAcc) acc <= Load ? op_a : acc - dl;
        if (LoadResult) res <= {res[6:0], QuotientBit};
    end
    always @(negedge Clock) if (Test !== 1'b0) test_bad++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {Load, DivShift, LoadAcc, LoadResult, QuotientBit, Busy, Done, DivByZero, Test};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 40) begin
            @(negedge Clock);
            n++;
        end
    endtask

    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int ecyc,
                           input logic [7:0] eq, input logic [7:0] er, input logic edz,
                           input int eiter, input int ela, input logic [7:0] eqs, input string tag);
        int cyc, iters, la;
        logic [7:0] qs;
        op_a = a; op_b = b; cyc = 1; iters = 0; la = 0; qs = '0;
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        check({tag, " load strobes"}, {Load, DivShift, LoadAcc, LoadResult, QuotientBit, Busy}, 6'b101101);
        while (!Done && cyc < 40) begin
            if (DivShift && LoadResult) begin
                iters++;
                la += int'(LoadAcc);
                qs = {qs[6:0], QuotientBit};
            end
            @(negedge Clock);
            cyc++;
        end
        check({tag, " done cycle"}, cyc, ecyc);
        check({tag, " done"}, Done, 1'b1);
        check({tag, " div0"}, DivByZero, edz);
        check({tag, " done strobes"}, {Load, DivShift, LoadAcc, LoadResult, Busy}, 5'b00001);
        check({tag, " iters"}, iters, eiter);
        check({tag, " loadacc"}, la, ela);
        check({tag, " qbits"}, qs, eqs);
        if (!edz) begin
            check({tag, " quotient"}, res, eq);
            check({tag, " remainder"}, acc, er);
        end
        @(negedge Clock);
        check({tag, " idle"}, outs(), 9'd0);
    endtask

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset outs", outs(), 9'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check("idle outs", outs(), 9'd0);

        run_div(8'd100, 8'd7, 11, 8'h0E, 8'd2, 1'b0, 8, 3, 8'b00001110, "100/7");
        run_div(8'd255, 8'd1, 11, 8'hFF, 8'd0, 1'b0, 8, 8, 8'hFF, "255/1");
        run_div(8'd5, 8'd9, 11, 8'h00, 8'd5, 1'b0, 8, 0, 8'h00, "5/9");
`ifdef DIVSEQ_DIV0_CHECK_EN
        run_div(8'd37, 8'd0, 3, 8'h00, 8'd0, 1'b1, 0, 0, 8'h00, "37/0");
`else
        run_div(8'd37, 8'd0, 11, 8'hFF, 8'd37, 1'b0, 8, 8, 8'hFF, "37/0");
`endif

        op_a = 8'd100; op_b = 8'd7;
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (3) @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        wait_done(n);
        check("repulse done cycle", 5 + n, 11);
        check("repulse quotient", res, 8'h0E);
        Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        check("start in done ignored", Busy, 1'b0);
        n = 0;
        repeat (15) begin
            @(negedge Clock);
            n += int'(Done) + int'(Busy);
        end
        check("no second division", n, 0);

        @(negedge Clock); Start = 1'b1;
        wait_done(n);
        check("held first done", Done, 1'b1);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!Done && n < 40);
        check("back-to-back spacing", n, 12);
        check("back-to-back quotient", res, 8'h0E);
        Start = 1'b0;
        @(negedge Clock);
        check("held released idle", Busy, 1'b0);

        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (5) @(negedge Clock);
        check("in 4th iter", {DivShift, LoadResult, Busy}, 3'b111);
        #2 Reset = 1'b1;
        #1 check("async reset outs", outs(), 9'd0);
        @(negedge Clock); Reset = 1'b0;
        @(negedge Clock);
        check("post reset idle", outs(), 9'd0);
        run_div(8'd200, 8'd10, 11, 8'd20, 8'd0, 1'b0, 8, 2, 8'b00010100, "200/10");

        check("test tied low", test_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
Control FSM for the 8-bit Type 2 restoring divider built from the bitslice datapath.
- Accepts a Start request and loads dividend and divisor into the slice array.
- Steps the shift/compare/conditional-subtract loop once per quotient bit, using the borrow and zero chains returned by the slices.
- Reports Busy and Done.
- Sits one level above the bitslice array in the divider top level.

Parameters:
N, 8, number of quotient bits / iterations (datapath width)
CNT_W, 3, iteration counter width, equal to clog2(N)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request a division; accepted only in IDLE
nBorrow  input  1  nBorrowOut of MSB slice; 1 = ACC >= DivisorL, no borrow
nZ  input  1  nZOut of zero chain over DivisorH; 0 = DivisorH all zero
Load  output  1  load Operand2 into DivisorH, clear DivisorL
DivShift  output  1  shift divisor pair {DH,DL} right one bit, 0 into MSB
LoadAcc  output  1  load ACC (dividend in LOAD, difference in ITER)
LoadResult  output  1  shift Result left by one
QuotientBit  output  1  bit shifted into Result LSB (drives SHLinResult)
Test  output  1  scan enable to slices; tied 0 by this block
Busy  output  1  high from Start accept until the cycle after Done
Done  output  1  one-cycle pulse when Result/ACC hold quotient/remainder
DivByZero  output  1  error flag, valid with Done (see Optional Feature)

Behaviour:
States:
- IDLE: all outputs 0; Start=1 -> LOAD.
- LOAD: Load=1, LoadAcc=1, LoadResult=1 with QuotientBit=0 (Result cleared over 8 shifts), Busy=1 -> ALIGN.
- ALIGN: DivShift=1, Busy=1, counter<=0 -> ITER.
- ITER: Busy=1, DivShift=1, LoadResult=1.
  - ok = nBorrow & ~nZ; LoadAcc=ok, QuotientBit=ok (Mealy, combinational from inputs).
  - Counter increments each cycle; leave to DONE after counter==N-1 (exactly N ITER cycles).
- DONE: Done=1, Busy=1, no load/shift strobes -> IDLE.
Timing and rules:
- Latency: Start sampled high in IDLE at edge k -> Done high in cycle k+1+N+2 (11 cycles for N=8).
- Divisor alignment: after ALIGN, divisor sits at weight 2^(N-1). The ITER cycle with counter c tests weight 2^(N-1-c); the last test is DivisorH==0, DivisorL==divisor.
- Counter wraps only via the ITER->DONE transition; never compares beyond N-1.
- Start while not IDLE (including the DONE cycle) is ignored, not queued.
- Start held high continuously: a new division is accepted in IDLE on the cycle after DONE.
- Reset asserted at any time, including mid-ITER: state=IDLE, counter=0, all outputs 0 immediately (asynchronous). Datapath contents are undefined afterwards; the next Start reloads them.
- Outputs other than LoadAcc/QuotientBit are decoded from state only (Moore). No output glitches from counter decode.
- Unused/illegal state encodings recover to IDLE on the next edge.

Optional Feature:
Macro DIVSEQ_DIV0_CHECK_EN.
- Defined: in ALIGN the divisor is still wholly in DivisorH; if nZ==0, go to ERR instead of ITER.
  - ERR: Done=1, DivByZero=1, Busy=1 for one cycle -> IDLE.
  - No ITER cycles, no LoadAcc/LoadResult strobes after LOAD.
  - Done for div-by-zero arrives at k+3.
- Not defined: no check. DivByZero is tied 0 and ERR does not exist. Division by 0 runs the normal N cycles and yields quotient 0xFF, remainder = dividend.

Test Plan (bench includes a behavioural 8-bit bitslice model):
- 100/7: Start pulse -> Done at cycle 11; quotient 14 (0x0E), remainder 2; QuotientBit sequence MSB-first 00001110.
- 255/1 and 5/9: -> Q=255 R=0 (LoadAcc high all 8 ITER cycles); Q=0 R=5 (LoadAcc never high in ITER).
- 37/0 with DIVSEQ_DIV0_CHECK_EN: Done+DivByZero at cycle 3, no ITER. Without the macro: Done at 11, Q=0xFF, R=37, DivByZero=0.
- Start re-pulsed during ITER and during DONE -> ignored; a single Done. Start held high -> back-to-back divisions 12 cycles apart.
- Reset asserted in the 4th ITER cycle -> all outputs 0 the same cycle, state IDLE. A following 200/10 gives Q=20, R=0.
- Test output stays 0 throughout every scenario.
